// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX pipeline register that sits directly in front of the ALU. It captures
//   one decoded instruction and its register-file operands, resolves RAW
//   hazards against the EX, MEM and WB writers at capture time, and drives the
//   ALU operand inputs from registers. There is a valid/ready handshake on both
//   sides, with stall (out_ready low) and flush (branch redirect).
//
//   Build option: define ALU_ISSUE_BYPASS_EN to enable the bypass network.
//   Without it, operands come straight from the register file (r0 still reads
//   zero) and the decoder is responsible for interlocking.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   flush                         kill the held instruction, block capture
//   in_valid / in_ready           decoder handshake
//   in_opcode, in_rs*_idx/val,
//   in_is_imm, in_imm,
//   in_rd_idx, in_rd_we           decoded instruction and regfile read data
//   alu_result                    EX bypass source (result of held instruction)
//   mem_we/idx/data, wb_we/idx/data  MEM and WB writers
//   out_valid / out_ready         downstream handshake
//   opcode, in1, in2_is_imm,
//   in2_imm, in2_readbus          registered ALU inputs
//   rd_idx, rd_we                 destination carried downstream
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WORD = 32,
    parameter int OPW  = 6,
    parameter int IMMW = 16,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_opcode,
    input  logic [RIDX-1:0] in_rs1_idx,
    input  logic [RIDX-1:0] in_rs2_idx,
    input  logic [WORD-1:0] in_rs1_val,
    input  logic [WORD-1:0] in_rs2_val,
    input  logic            in_is_imm,
    input  logic [IMMW-1:0] in_imm,
    input  logic [RIDX-1:0] in_rd_idx,
    input  logic            in_rd_we,
    input  logic [WORD-1:0] alu_result,
    input  logic            mem_we,
    input  logic [RIDX-1:0] mem_idx,
    input  logic [WORD-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_idx,
    input  logic [WORD-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OPW-1:0]  opcode,
    output logic [WORD-1:0] in1,
    output logic            in2_is_imm,
    output logic [IMMW-1:0] in2_imm,
    output logic [WORD-1:0] in2_readbus,
    output logic [RIDX-1:0] rd_idx,
    output logic            rd_we
);

    logic            vld_p0;
    logic [OPW-1:0]  opcode_p0;
    logic [WORD-1:0] in1_p0;
    logic            is_imm_p0;
    logic [IMMW-1:0] imm_p0;
    logic [WORD-1:0] rs2_p0;
    logic [RIDX-1:0] rd_idx_p0;
    logic            rd_we_p0;

    logic            advance;
    logic            capture;
    logic [WORD-1:0] rs1_resolved;
    logic [WORD-1:0] rs2_resolved;

    assign advance  = vld_p0 && out_ready;
    assign in_ready = !flush && (!vld_p0 || out_ready);
    assign capture  = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    // The held instruction forwards its ALU result only in the cycle it leaves
    // this stage; that is exactly when a dependent younger one can be captured.
    logic ex_fwd;
    assign ex_fwd = advance && rd_we_p0;

    // Youngest producer wins: EX, then MEM, then WB, then the register file.
    function automatic logic [WORD-1:0] resolve_operand(
        input logic [RIDX-1:0] idx,
        input logic [WORD-1:0] rf_val,
        input logic            ex_hit_en,
        input logic [RIDX-1:0] ex_idx,
        input logic [WORD-1:0] ex_val,
        input logic            m_we,
        input logic [RIDX-1:0] m_idx,
        input logic [WORD-1:0] m_val,
        input logic            w_we,
        input logic [RIDX-1:0] w_idx,
        input logic [WORD-1:0] w_val
    );
        logic [WORD-1:0] r;
        if (idx == '0)                        r = '0;
        else if (ex_hit_en && ex_idx == idx)  r = ex_val;
        else if (m_we && m_idx == idx)        r = m_val;
        else if (w_we && w_idx == idx)        r = w_val;
        else                                  r = rf_val;
        return r;
    endfunction

    assign rs1_resolved = resolve_operand(in_rs1_idx, in_rs1_val, ex_fwd, rd_idx_p0,
                                          alu_result, mem_we, mem_idx, mem_data,
                                          wb_we, wb_idx, wb_data);
    // rs2 is resolved even for immediate forms; the ALU simply ignores it.
    assign rs2_resolved = resolve_operand(in_rs2_idx, in_rs2_val, ex_fwd, rd_idx_p0,
                                          alu_result, mem_we, mem_idx, mem_data,
                                          wb_we, wb_idx, wb_data);
`else
    function automatic logic [WORD-1:0] resolve_operand(
        input logic [RIDX-1:0] idx,
        input logic [WORD-1:0] rf_val
    );
        return (idx == '0) ? '0 : rf_val;
    endfunction

    assign rs1_resolved = resolve_operand(in_rs1_idx, in_rs1_val);
    assign rs2_resolved = resolve_operand(in_rs2_idx, in_rs2_val);

    // Bypass sources stay on the port list for a uniform interface.
    logic unused_bypass;
    assign unused_bypass = ^{alu_result, mem_we, mem_idx, mem_data,
                             wb_we, wb_idx, wb_data};
`endif

    // ---- stage p0: ID/EX register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            opcode_p0 <= '0;
            in1_p0    <= '0;
            is_imm_p0 <= 1'b0;
            imm_p0    <= '0;
            rs2_p0    <= '0;
            rd_idx_p0 <= '0;
            rd_we_p0  <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (capture) begin
            vld_p0    <= 1'b1;
            opcode_p0 <= in_opcode;
            in1_p0    <= rs1_resolved;
            is_imm_p0 <= in_is_imm;
            imm_p0    <= in_imm;
            rs2_p0    <= rs2_resolved;
            rd_idx_p0 <= in_rd_idx;
            rd_we_p0  <= in_rd_we && (in_rd_idx != '0);
        end else if (advance) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid   = vld_p0;
    assign opcode      = opcode_p0;
    assign in1         = in1_p0;
    assign in2_is_imm  = is_imm_p0;
    assign in2_imm     = imm_p0;
    assign in2_readbus = rs2_p0;
    assign rd_idx      = rd_idx_p0;
    assign rd_we       = rd_we_p0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage: a table of single-capture vectors with
//   hand-computed results (for both bypass and non-bypass builds), plus
//   sequences for EX bypass, stall, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs1_idx, in_rs2_idx;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic        in_is_imm;
    logic [15:0] in_imm;
    logic [4:0]  in_rd_idx;
    logic        in_rd_we;
    logic [31:0] alu_result;
    logic        mem_we;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [31:0] in1;
    logic        in2_is_imm;
    logic [15:0] in2_imm;
    logic [31:0] in2_readbus;
    logic [4:0]  rd_idx;
    logic        rd_we;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_is_imm(in_is_imm), .in_imm(in_imm),
        .in_rd_idx(in_rd_idx), .in_rd_we(in_rd_we),
        .alu_result(alu_result),
        .mem_we(mem_we), .mem_idx(mem_idx), .mem_data(mem_data),
        .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .in1(in1), .in2_is_imm(in2_is_imm),
        .in2_imm(in2_imm), .in2_readbus(in2_readbus),
        .rd_idx(rd_idx), .rd_we(rd_we)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rs1, input logic [31:0] v1,
                             input logic [4:0] rs2, input logic [31:0] v2, input logic imm_f,
                             input logic [15:0] imm, input logic [4:0] rd, input logic we);
        in_opcode  = op;  in_rs1_idx = rs1; in_rs1_val = v1;
        in_rs2_idx = rs2; in_rs2_val = v2;  in_is_imm  = imm_f;
        in_imm     = imm; in_rd_idx  = rd;  in_rd_we   = we;
    endtask

    task automatic clr_fwd();
        mem_we = 1'b0; mem_idx = '0; mem_data = '0;
        wb_we  = 1'b0; wb_idx  = '0; wb_data  = '0;
        alu_result = '0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1, rs2;
        logic [31:0] v1, v2;
        logic        is_imm;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic        m_we;
        logic [4:0]  m_idx;
        logic [31:0] m_data;
        logic        w_we;
        logic [4:0]  w_idx;
        logic [31:0] w_data;
        logic [31:0] e_in1_byp, e_in2_byp;
        logic [31:0] e_in1_nb,  e_in2_nb;
        logic        e_rd_we;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // op rs1 rs2 v1 v2 imm? imm rd we | mem | wb | in1/in2 bypass | in1/in2 plain | rd_we
        vecs[0] = '{6'd1, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 16'h0, 5'd3, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 1'b1};
        vecs[1] = '{6'd2, 5'd3, 5'd2, 32'h11, 32'h22, 1'b0, 16'h0, 5'd4, 1'b1,
                    1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 32'h66, 32'h55, 32'h22, 32'h11, 32'h22, 1'b1};
        vecs[2] = '{6'd3, 5'd2, 5'd2, 32'h33, 32'h44, 1'b0, 16'h0, 5'd5, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h66, 32'h66, 32'h66, 32'h33, 32'h44, 1'b1};
        vecs[3] = '{6'd4, 5'd0, 5'd4, 32'hDEAD, 32'h8, 1'b0, 16'h0, 5'd6, 1'b1,
                    1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h0, 32'h8, 1'b1};
        vecs[4] = '{6'd5, 5'd1, 5'd5, 32'h3, 32'hAB, 1'b1, 16'hFFFF, 5'd7, 1'b1,
                    1'b1, 5'd5, 32'hCD, 1'b0, 5'd0, 32'h0, 32'h3, 32'hCD, 32'h3, 32'hAB, 1'b1};
        vecs[5] = '{6'd6, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 16'h0, 5'd0, 1'b1,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h1, 32'h2, 32'h1, 32'h2, 1'b0};
        vecs[6] = '{6'd7, 5'd8, 5'd7, 32'h1, 32'h2, 1'b0, 16'h1234, 5'd9, 1'b1,
                    1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 32'h80, 32'h70, 32'h1, 32'h2, 1'b1};
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_instr(6'd0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 16'h0, 5'd0, 1'b0);
        clr_fwd();
        #3;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in1", in1, 32'd0);
        chk("reset in2_readbus", in2_readbus, 32'd0);
        chk("reset opcode", {26'b0, opcode}, 32'd0);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        #5 rst_n = 1'b1;
        tick();

        // ---- table of single captures, each followed by a drain cycle ----
        for (int i = 0; i < 7; i++) begin
            set_instr(vecs[i].op, vecs[i].rs1, vecs[i].v1, vecs[i].rs2, vecs[i].v2,
                      vecs[i].is_imm, vecs[i].imm, vecs[i].rd, vecs[i].rd_we);
            mem_we = vecs[i].m_we; mem_idx = vecs[i].m_idx; mem_data = vecs[i].m_data;
            wb_we  = vecs[i].w_we; wb_idx  = vecs[i].w_idx; wb_data  = vecs[i].w_data;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, vecs[i].op});
            chk($sformatf("v%0d in1", i), in1, BYP ? vecs[i].e_in1_byp : vecs[i].e_in1_nb);
            chk($sformatf("v%0d in2_readbus", i), in2_readbus,
                BYP ? vecs[i].e_in2_byp : vecs[i].e_in2_nb);
            chk($sformatf("v%0d in2_is_imm", i), {31'b0, in2_is_imm}, {31'b0, vecs[i].is_imm});
            chk($sformatf("v%0d in2_imm", i), {16'b0, in2_imm}, {16'b0, vecs[i].imm});
            chk($sformatf("v%0d rd_idx", i), {27'b0, rd_idx}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d rd_we", i), {31'b0, rd_we}, {31'b0, vecs[i].e_rd_we});
            in_valid = 1'b0;
            clr_fwd();
            tick();
            chk($sformatf("v%0d drained", i), {31'b0, out_valid}, 32'd0);
        end

        // ---- EX bypass: ADD r3=r1+r2, SUB r3=r3-r1, then EX beats MEM/WB ----
        set_instr(6'd1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 16'h0, 5'd3, 1'b1);
        in_valid = 1'b1;
        tick();
        chk("ex add in1", in1, 32'd5);
        set_instr(6'd2, 5'd3, 32'h999, 5'd1, 32'd5, 1'b0, 16'h0, 5'd3, 1'b1);
        alu_result = 32'd12;
        tick();
        chk("ex sub out_valid", {31'b0, out_valid}, 32'd1);
        chk("ex sub in1", in1, BYP ? 32'd12 : 32'h999);
        chk("ex sub in2", in2_readbus, 32'd5);
        set_instr(6'd3, 5'd3, 32'h11, 5'd0, 32'h5, 1'b0, 16'h0, 5'd5, 1'b1);
        alu_result = 32'h77;
        mem_we = 1'b1; mem_idx = 5'd3; mem_data = 32'h55;
        wb_we  = 1'b1; wb_idx  = 5'd3; wb_data  = 32'h66;
        tick();
        chk("ex prio in1", in1, BYP ? 32'h77 : 32'h11);
        chk("ex prio in2 r0", in2_readbus, 32'd0);
        in_valid = 1'b0;
        clr_fwd();
        tick();
        chk("ex drained", {31'b0, out_valid}, 32'd0);

        // ---- stall holding ADDI imm=0xFFFF for 3 cycles ----
        set_instr(6'd4, 5'd1, 32'd5, 5'd0, 32'h0, 1'b1, 16'hFFFF, 5'd6, 1'b1);
        in_valid = 1'b1;
        tick();
        chk("stall cap out_valid", {31'b0, out_valid}, 32'd1);
        set_instr(6'd5, 5'd2, 32'h22, 5'd0, 32'h0, 1'b0, 16'h1234, 5'd7, 1'b1);
        out_ready = 1'b0;
        mem_we = 1'b1; mem_idx = 5'd1; mem_data = 32'hEE;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'd0);
            tick();
            chk($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stall%0d opcode", c), {26'b0, opcode}, 32'd4);
            chk($sformatf("stall%0d in1", c), in1, 32'd5);
            chk($sformatf("stall%0d is_imm", c), {31'b0, in2_is_imm}, 32'd1);
            chk($sformatf("stall%0d imm", c), {16'b0, in2_imm}, 32'h0000FFFF);
        end
        out_ready = 1'b1;
        clr_fwd();
        #1;
        chk("release in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("release out_valid", {31'b0, out_valid}, 32'd1);
        chk("release opcode", {26'b0, opcode}, 32'd5);
        chk("release in1", in1, 32'h22);
        chk("release is_imm", {31'b0, in2_is_imm}, 32'd0);
        chk("release rd_idx", {27'b0, rd_idx}, 32'd7);

        // ---- flush with a live instruction and a pending one ----
        flush = 1'b1;
        set_instr(6'd6, 5'd1, 32'h1, 5'd0, 32'h0, 1'b0, 16'h0, 5'd8, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("flush in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("flush out_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush nothing captured", {31'b0, out_valid}, 32'd0);

        // ---- asynchronous reset while stalled ----
        set_instr(6'd7, 5'd1, 32'h42, 5'd0, 32'h0, 1'b0, 16'h0, 5'd2, 1'b1);
        in_valid = 1'b1;
        tick();
        chk("areset cap out_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("areset stalled", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset out_valid", {31'b0, out_valid}, 32'd0);
        chk("areset in1", in1, 32'd0);
        chk("areset opcode", {26'b0, opcode}, 32'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("after reset out_valid", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures a decoded ALU instruction and its register-file operands from the decoder, resolves RAW hazards by bypassing results from EX, MEM and WB, and drives the ALU operand inputs (opcode, in1, in2_is_imm, in2_imm, in2_readbus) from registers.
- Uses a valid/ready handshake on both sides; supports stall and flush.

Parameters:
- WORD, 32, data word width; matches the ALU word size.
- OPW, 6, opcode width.
- IMMW, 16, immediate width; passed through raw, the ALU sign-extends.
- RIDX, 5, register index width; register 0 is hardwired zero.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of the held instruction (branch redirect)
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_opcode  in  OPW  decoded opcode
- in_rs1_idx, in_rs2_idx  in  RIDX each  source register indices
- in_rs1_val, in_rs2_val  in  WORD each  register-file read data
- in_is_imm  in  1  second operand is the immediate
- in_imm  in  IMMW  raw immediate
- in_rd_idx  in  RIDX  destination register
- in_rd_we  in  1  instruction writes rd
- alu_result  in  WORD  current ALU output (EX bypass source)
- mem_we, mem_idx, mem_data  in  1/RIDX/WORD  MEM-stage writer
- wb_we, wb_idx, wb_data  in  1/RIDX/WORD  WB-stage writer (same-cycle regfile write)
- out_valid  out  1  ALU inputs hold a live instruction
- out_ready  in  1  downstream (EX/MEM register) accepts the ALU result
- opcode  out  OPW  to ALU
- in1  out  WORD  to ALU
- in2_is_imm  out  1  to ALU
- in2_imm  out  IMMW  to ALU
- in2_readbus  out  WORD  to ALU
- rd_idx  out  RIDX; rd_we  out  1  carried to downstream

Behaviour:
- Reset: out_valid=0 and all data outputs = 0, applied asynchronously while rst_n=0. in_ready is combinational and therefore 0 whenever flush=1.
- in_ready = !flush && (!out_valid || out_ready). Capture happens when in_valid && in_ready; outputs update on the next rising edge (latency 1).
- Advance when out_valid && out_ready. If advancing with no capture, out_valid goes to 0. If capturing, out_valid goes to 1.
- Stall (out_valid && !out_ready): all outputs hold and nothing is captured.
- Flush has priority over every other event: out_valid goes to 0 next edge; data outputs may hold stale values; nothing is captured.
- Bypass, per source operand s (rs1 and rs2), evaluated at capture:
  - If s_idx == 0, the operand is 0.
  - Else if out_valid && out_ready && rd_we && rd_idx == s_idx, use alu_result (EX).
  - Else if mem_we && mem_idx == s_idx, use mem_data.
  - Else if wb_we && wb_idx == s_idx, use wb_data.
  - Else use in_s_val.
  - Priority is EX > MEM > WB: youngest producer wins.
- rs2 is bypassed even when in_is_imm=1; the ALU ignores in2_readbus in that case.
- in2_imm, in2_is_imm, opcode, rd_idx and rd_we are registered unchanged. rd_we is forced to 0 when in_rd_idx == 0.
- Load-use hazards are not covered: the decoder must not issue a consumer of a load still in EX.
- Operands are captured once at capture time and never re-bypassed while stalled. All producers older than the held instruction have already been observed at capture.

Optional Feature:
- ALU_ISSUE_BYPASS_EN defined: bypass network as above.
- Not defined: in1 and in2_readbus take in_rs1_val and in_rs2_val directly, except register 0, which still reads 0. The mem_*, wb_* and alu_result ports remain but are ignored. The decoder is responsible for interlocking.

Test Plan:
- Reset, then a single ADD (r1=5, r2=7, rd=r3) with out_ready=1 -> one cycle later out_valid=1, in1=5, in2_readbus=7, rd_idx=3; the next cycle out_valid=0.
- Back-to-back ADD r3=r1+r2, then SUB r4=r3-r1 with alu_result=12 -> second capture has in1=12 (EX bypass), not the stale regfile value.
- Same cycle: mem_we (idx 3, data 0x55), wb_we (idx 3, data 0x66), EX idle -> in1=0x55. Repeat with EX writing r3 and alu_result=0x77 -> in1=0x77.
- out_ready=0 for 3 cycles while holding ADDI (imm=0xFFFF) -> in_ready=0 and outputs stable (in2_is_imm=1, in2_imm=0xFFFF); release -> next instruction is captured.
- flush asserted with in_valid=1 -> in_ready=0, out_valid=0 next cycle, nothing captured. rs1_idx=0 with mem_we to idx 0 -> in1=0.
- rst_n pulled low mid-stall -> out_valid=0 immediately, without waiting for a clock edge.
